// File: rtl/imem_pkg.sv
// Shared types and constants for the instruction-memory responder.
package imem_pkg;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    RESP
  } state_t;

  localparam logic [31:0] NOP_INSTR = 32'h0;
  localparam int          WAIT_MAX  = 15;
  localparam int          CNT_W     = $clog2(WAIT_MAX + 1);

endpackage

// File: rtl/imem_ram.sv
// Word-organised instruction store: one synchronous read port, one write port.
// A read and a write to the same word in one cycle returns the previous contents.
module imem_ram
  import imem_pkg::*;
#(
  parameter int N       = 32,
  parameter int DEPTH_W = 10
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               rd_en_i,
  input  logic [DEPTH_W-1:0] rd_addr_i,
  output logic [N-1:0]       rd_data_o,
  input  logic               wr_en_i,
  input  logic [DEPTH_W-1:0] wr_addr_i,
  input  logic [N-1:0]       wr_data_i
);

  logic [N-1:0] mem_q [2**DEPTH_W];
  logic [N-1:0] rd_data_q;

  always_ff @(posedge clk) begin
    if (wr_en_i) begin
      mem_q[wr_addr_i] <= wr_data_i;
    end
  end

  // Only the read-data register is reset; the array keeps its contents.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_data_q <= '0;
    end else if (rd_en_i) begin
      rd_data_q <= mem_q[rd_addr_i];
    end
  end

  assign rd_data_o = rd_data_q;

endmodule

// File: rtl/imem_responder.sv
// Fetch-side instruction memory responder: wait-state sequencing, redirect/flush
// handling, misalignment reporting and the memory stall towards the hazard unit.
module imem_responder
  import imem_pkg::*;
#(
  parameter int N       = 32,
  parameter int DEPTH_W = 10,
  parameter int WAIT    = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N-1:0]       PCF,
  input  logic               ReqF,
  input  logic               FlushF,
  output logic [N-1:0]       InstrF,
  output logic               InstrValidF,
  output logic               MisalignF,
  output logic               StallMemF,
  input  logic               LdEn,
  input  logic [DEPTH_W-1:0] LdAddr,
  input  logic [N-1:0]       LdData
);

  localparam logic [CNT_W-1:0] WAIT_CNT = CNT_W'(WAIT);

  state_t           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [N-1:0]     addr_q;
  logic             valid_q;
  logic             misalign_q;

  logic             pc_misaligned;
  logic             redirect;
  logic             rd_en;
  logic [N-1:0]     rd_data;

  assign pc_misaligned = |PCF[1:0];
  assign redirect      = ReqF && (PCF != addr_q);
  assign rd_en         = (state_q == BUSY) && !FlushF && !redirect && (cnt_q == '0);

  imem_ram #(
    .N       (N),
    .DEPTH_W (DEPTH_W)
  ) u_ram (
    .clk       (clk),
    .rst       (rst),
    .rd_en_i   (rd_en),
    .rd_addr_i (addr_q[DEPTH_W+1:2]),
    .rd_data_o (rd_data),
    .wr_en_i   (LdEn),
    .wr_addr_i (LdAddr),
    .wr_data_i (LdData)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      addr_q     <= '0;
      valid_q    <= 1'b0;
      misalign_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          valid_q    <= 1'b0;
          misalign_q <= 1'b0;
          // Misaligned requests skip the array and answer with a NOP next cycle.
          if (!FlushF && ReqF) begin
            addr_q <= PCF;
            if (pc_misaligned) begin
              state_q    <= RESP;
              valid_q    <= 1'b1;
              misalign_q <= 1'b1;
            end else begin
              cnt_q   <= WAIT_CNT;
              state_q <= BUSY;
            end
          end
        end
        BUSY: begin
          if (FlushF) begin
            state_q <= IDLE;
            cnt_q   <= '0;
          end else if (redirect) begin
            addr_q <= PCF;
            if (pc_misaligned) begin
              state_q    <= RESP;
              cnt_q      <= '0;
              valid_q    <= 1'b1;
              misalign_q <= 1'b1;
            end else begin
              cnt_q <= WAIT_CNT;
            end
          end else if (cnt_q != '0) begin
            cnt_q <= cnt_q - CNT_W'(1);
          end else begin
            state_q    <= RESP;
            valid_q    <= 1'b1;
            misalign_q <= 1'b0;
          end
        end
        RESP: begin
          state_q    <= IDLE;
          valid_q    <= 1'b0;
          misalign_q <= 1'b0;
        end
        default: begin
          state_q    <= IDLE;
          cnt_q      <= '0;
          valid_q    <= 1'b0;
          misalign_q <= 1'b0;
        end
      endcase
    end
  end

  // A flush arriving in the response cycle must kill that response immediately.
  assign InstrValidF = valid_q & ~FlushF;
  assign MisalignF   = misalign_q;
  assign InstrF      = misalign_q ? N'(NOP_INSTR) : rd_data;
  assign StallMemF   = ReqF & ~((state_q == RESP) && (PCF == addr_q));

endmodule

// File: tb/tb_imem_responder.sv
// Scoreboard bench for imem_responder: WAIT=2 main instance plus a WAIT=0 instance.
module tb_imem_responder;
  import imem_pkg::*;

  localparam int WAIT_TB = 2;

  typedef struct {
    int          cyc;
    logic [31:0] data;
    logic        mis;
  } exp_t;

  logic        clk;
  logic        rst;
  logic [31:0] PCF;
  logic        ReqF;
  logic        FlushF;
  logic [31:0] InstrF;
  logic        InstrValidF;
  logic        MisalignF;
  logic        StallMemF;
  logic        LdEn;
  logic [9:0]  LdAddr;
  logic [31:0] LdData;

  logic [31:0] pc0;
  logic        req0;
  logic        flush0;
  logic [31:0] instr0;
  logic        valid0;
  logic        mis0;
  logic        stall0;
  logic        ld0En;
  logic [9:0]  ld0Addr;
  logic [31:0] ld0Data;

  int          cyc = 0;
  int          vectors = 0;
  int          miscompares = 0;
  exp_t        q[$];
  exp_t        q0[$];
  logic [31:0] memModel [1024];

  imem_responder #(.N(32), .DEPTH_W(10), .WAIT(WAIT_TB)) dut (
    .clk(clk), .rst(rst), .PCF(PCF), .ReqF(ReqF), .FlushF(FlushF),
    .InstrF(InstrF), .InstrValidF(InstrValidF), .MisalignF(MisalignF),
    .StallMemF(StallMemF), .LdEn(LdEn), .LdAddr(LdAddr), .LdData(LdData)
  );

  imem_responder #(.N(32), .DEPTH_W(10), .WAIT(0)) dut0 (
    .clk(clk), .rst(rst), .PCF(pc0), .ReqF(req0), .FlushF(flush0),
    .InstrF(instr0), .InstrValidF(valid0), .MisalignF(mis0),
    .StallMemF(stall0), .LdEn(ld0En), .LdAddr(ld0Addr), .LdData(ld0Data)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    vectors++;
    if (observed !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: observed %h expected %h (cycle %0d)", tag, observed, expected, cyc);
    end
  endtask

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic loadWord(input logic [9:0] a, input logic [31:0] d);
    LdEn   = 1'b1;
    LdAddr = a;
    LdData = d;
    memModel[a] = d;
    nextCycle();
    LdEn = 1'b0;
  endtask

  // Drives a fetch request this cycle; optionally records the expected response.
  task automatic applyStimulus(input logic [31:0] pc, input bit doPush, output int vcyc);
    exp_t        e;
    logic [9:0]  idx;
    bit          mis;
    PCF  = pc;
    ReqF = 1'b1;
    idx  = pc[11:2];
    mis  = (pc[1:0] != 2'b00);
    vcyc = mis ? cyc + 1 : cyc + WAIT_TB + 2;
    if (doPush) begin
      e.cyc  = vcyc;
      e.data = mis ? 32'h0 : memModel[idx];
      e.mis  = mis;
      q.push_back(e);
    end
  endtask

  // Checks the stall each cycle up to the response, then releases the request.
  task automatic waitResp(input int vcyc);
    bit done;
    done = 1'b0;
    while (!done) begin
      @(negedge clk);
      checkOutput("stall", 32'(StallMemF), 32'(cyc != vcyc));
      if (cyc >= vcyc) done = 1'b1;
    end
    nextCycle();
    ReqF = 1'b0;
  endtask

  always @(negedge clk) begin : monMain
    exp_t e;
    if (!rst && InstrValidF) begin
      if (q.size() == 0) begin
        checkOutput("spurious_valid", 32'(InstrValidF), 32'h0);
      end else begin
        e = q.pop_front();
        checkOutput("instr", InstrF, e.data);
        checkOutput("misalign", 32'(MisalignF), 32'(e.mis));
        checkOutput("latency", 32'(cyc), 32'(e.cyc));
      end
    end
  end

  always @(negedge clk) begin : monWait0
    exp_t e;
    if (!rst && valid0) begin
      if (q0.size() == 0) begin
        checkOutput("w0_spurious_valid", 32'(valid0), 32'h0);
      end else begin
        e = q0.pop_front();
        checkOutput("w0_instr", instr0, e.data);
        checkOutput("w0_latency", 32'(cyc), 32'(e.cyc));
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int   v;
    int   c;
    exp_t e;
    rst = 1'b1; PCF = '0; ReqF = 1'b0; FlushF = 1'b0;
    LdEn = 1'b0; LdAddr = '0; LdData = '0;
    pc0 = '0; req0 = 1'b0; flush0 = 1'b0;
    ld0En = 1'b0; ld0Addr = '0; ld0Data = '0;
    for (int i = 0; i < 1024; i++) memModel[i] = 32'h0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    @(negedge clk);
    checkOutput("rst_instr", InstrF, 32'h0);
    checkOutput("rst_valid", 32'(InstrValidF), 32'h0);
    checkOutput("rst_misalign", 32'(MisalignF), 32'h0);
    checkOutput("rst_stall", 32'(StallMemF), 32'h0);
    checkOutput("rst_state", 32'(dut.state_q), 32'(IDLE));
    nextCycle();

    $display("[TB] loading program words");
    loadWord(10'd5, 32'hDEADBEEF);
    loadWord(10'd8, 32'h88888888);
    loadWord(10'd16, 32'h16161616);

    $display("[TB] basic read");
    applyStimulus(32'h14, 1'b1, v);
    waitResp(v);
    nextCycle();

    $display("[TB] flush mid-access");
    c = cyc;
    applyStimulus(32'h20, 1'b0, v);
    nextCycle();
    nextCycle();
    FlushF = 1'b1;
    nextCycle();
    FlushF = 1'b0;
    ReqF   = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (k == 0) checkOutput("flush_idle", 32'(dut.state_q), 32'(IDLE));
      checkOutput("flush_novalid", 32'(InstrValidF), 32'h0);
    end
    checkOutput("flush_window", 32'(cyc), 32'(c + 6));
    nextCycle();

    $display("[TB] redirect while busy");
    applyStimulus(32'h20, 1'b0, v);
    nextCycle();
    nextCycle();
    applyStimulus(32'h40, 1'b1, v);
    waitResp(v);
    nextCycle();

    $display("[TB] misaligned fetch");
    applyStimulus(32'h22, 1'b1, v);
    waitResp(v);
    nextCycle();

    $display("[TB] read/write collision");
    applyStimulus(32'h14, 1'b1, v);
    nextCycle();
    nextCycle();
    nextCycle();
    LdEn = 1'b1; LdAddr = 10'd5; LdData = 32'h1;
    memModel[5] = 32'h1;
    nextCycle();
    LdEn = 1'b0;
    waitResp(v);
    nextCycle();
    applyStimulus(32'h14, 1'b1, v);
    waitResp(v);
    nextCycle();

    $display("[TB] address wrap");
    applyStimulus(32'h1000_0014, 1'b1, v);
    waitResp(v);
    nextCycle();

    $display("[TB] asynchronous reset while busy");
    @(negedge clk);
    checkOutput("pre_rst_instr", InstrF, 32'h1);
    nextCycle();
    applyStimulus(32'h40, 1'b0, v);
    nextCycle();
    #1;
    rst = 1'b1;
    #1;
    checkOutput("arst_instr", InstrF, 32'h0);
    checkOutput("arst_valid", 32'(InstrValidF), 32'h0);
    checkOutput("arst_misalign", 32'(MisalignF), 32'h0);
    checkOutput("arst_state", 32'(dut.state_q), 32'(IDLE));
    checkOutput("arst_cnt", 32'(dut.cnt_q), 32'h0);
    ReqF = 1'b0;
    nextCycle();
    rst = 1'b0;
    nextCycle();

    $display("[TB] zero wait states");
    ld0En = 1'b1; ld0Addr = 10'd5; ld0Data = 32'hCAFEF00D;
    nextCycle();
    ld0En = 1'b0;
    pc0  = 32'h14;
    req0 = 1'b1;
    e.cyc  = cyc + 2;
    e.data = 32'hCAFEF00D;
    e.mis  = 1'b0;
    q0.push_back(e);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      checkOutput("w0_stall", 32'(stall0), 32'(k != 2));
      if (k != 2) nextCycle();
    end
    nextCycle();
    req0 = 1'b0;
    repeat (3) nextCycle();

    checkOutput("pending_main", 32'(q.size()), 32'h0);
    checkOutput("pending_w0", 32'(q0.size()), 32'h0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
